// File: rtl/hist_cdf_accum.sv
// hist_cdf_accum: per-frame intensity histogram with cumulative-distribution readout.
//   Bins each accepted 10-bit intensity (top BIN_BITS bits) into an internal count RAM.
//   On iFrameEnd it retires the update pipeline, sweeps all bins in ascending order,
//   streams the saturating running sum one bin per cycle, and zeroes each bin as it is
//   read so the next frame starts clean.
// Ports:
//   iCLK        pixel clock, rising edge
//   iRST        synchronous active-high reset
//   iIntensity  pixel intensity
//   iValid      iIntensity valid this cycle
//   iFrameEnd   pulse on the last pixel cycle of a frame
//   oBusy       clearing/draining/sweeping; pixels are dropped
//   oCdfValid   oCdfAddr/oCdfData valid this cycle
//   oCdfAddr    bin index of the current CDF entry
//   oCdfData    saturating sum of bins 0..oCdfAddr
//   oFrameDone  one-cycle pulse after the last CDF entry
//   oOverrun    sticky: input arrived while busy
module hist_cdf_accum #(
  parameter int unsigned BIN_BITS = 8,
  parameter int unsigned CNT_W    = 19
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [9:0]          iIntensity,
  input  logic                iValid,
  input  logic                iFrameEnd,
  output logic                oBusy,
  output logic                oCdfValid,
  output logic [BIN_BITS-1:0] oCdfAddr,
  output logic [CNT_W-1:0]    oCdfData,
  output logic                oFrameDone,
  output logic                oOverrun
);

  localparam int unsigned     NBins  = 1 << BIN_BITS;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [2:0] {StClear, StAccum, StDrain, StScan, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [BIN_BITS-1:0] r_addr, w_addr_next;
  logic                r_drain;
  logic [CNT_W-1:0]    r_mem [NBins];

  // Two-stage read-modify-write pipeline
  logic                r_s1_vld, r_s2_vld;
  logic [BIN_BITS-1:0] r_s1_bin, r_s2_bin;
  logic [CNT_W-1:0]    r_s2_cnt;

  logic [CNT_W-1:0]    r_sum;
  logic                r_busy, r_cdf_vld, r_frame_done, r_overrun;
  logic [BIN_BITS-1:0] r_cdf_addr;
  logic [CNT_W-1:0]    r_cdf_data;

  logic                w_accept;
  logic [CNT_W-1:0]    w_old, w_inc, w_rd_scan, w_sum_sat;
  logic [CNT_W:0]      w_sum_wide;
  logic                w_we;
  logic [BIN_BITS-1:0] w_waddr;
  logic [CNT_W-1:0]    w_wdata;
  logic                w_unused;

  // Only the top BIN_BITS intensity bits select a bin
  assign w_unused = ^iIntensity;

  assign w_accept = (r_state == StAccum) && iValid;

  // Stage 2 has not written yet, so a same-bin hit must take its pending value
  assign w_old = (r_s2_vld && (r_s2_bin == r_s1_bin)) ? r_s2_cnt : r_mem[r_s1_bin];
  assign w_inc = (w_old == CntMax) ? w_old : w_old + CNT_W'(1);

  assign w_rd_scan  = r_mem[r_addr];
  assign w_sum_wide = {1'b0, r_sum} + {1'b0, w_rd_scan};
  assign w_sum_sat  = w_sum_wide[CNT_W] ? CntMax : w_sum_wide[CNT_W-1:0];

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    unique case (r_state)
      StClear: begin
        w_addr_next = r_addr + BIN_BITS'(1);
        if (&r_addr) w_state_next = StAccum;
      end
      StAccum: if (iFrameEnd) w_state_next = StDrain;
      StDrain: if (r_drain) w_state_next = StScan;
      StScan: begin
        w_addr_next = r_addr + BIN_BITS'(1);
        if (&r_addr) w_state_next = StDone;
      end
      StDone:  w_state_next = StAccum;
      default: w_state_next = StClear;
    endcase
  end

  // Single write port: sweep/clear zeroing, otherwise the pipeline write-back
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_addr;
    w_wdata = '0;
    if (r_state == StClear || r_state == StScan) begin
      w_we = 1'b1;
    end else if (r_s2_vld) begin
      w_we    = 1'b1;
      w_waddr = r_s2_bin;
      w_wdata = r_s2_cnt;
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_we && !iRST) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= StClear;
      r_addr       <= '0;
      r_drain      <= 1'b0;
      r_s1_vld     <= 1'b0;
      r_s1_bin     <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_bin     <= '0;
      r_s2_cnt     <= '0;
      r_sum        <= '0;
      r_busy       <= 1'b1;
      r_cdf_vld    <= 1'b0;
      r_cdf_addr   <= '0;
      r_cdf_data   <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_addr       <= w_addr_next;
      r_drain      <= (r_state == StDrain) ? ~r_drain : 1'b0;
      r_s1_vld     <= w_accept;
      r_s1_bin     <= iIntensity[9 -: BIN_BITS];
      r_s2_vld     <= r_s1_vld;
      r_s2_bin     <= r_s1_bin;
      r_s2_cnt     <= w_inc;
      r_busy       <= (w_state_next != StAccum);
      r_cdf_vld    <= (r_state == StScan);
      r_frame_done <= (r_state == StDone);
      r_overrun    <= r_overrun | (r_busy & (iValid | iFrameEnd));
      if (r_state == StScan) begin
        r_sum      <= w_sum_sat;
        r_cdf_addr <= r_addr;
        r_cdf_data <= w_sum_sat;
      end else if (r_state == StDone) begin
        r_sum <= '0;
      end
    end
  end

  assign oBusy      = r_busy;
  assign oCdfValid  = r_cdf_vld;
  assign oCdfAddr   = r_cdf_addr;
  assign oCdfData   = r_cdf_data;
  assign oFrameDone = r_frame_done;
  assign oOverrun   = r_overrun;

endmodule

// File: tb/tb_hist_cdf_accum.sv
// Bench for hist_cdf_accum: a wide-count instance and a 4-bit-count instance share the
// same stimulus; a histogram model produces the expected CDF for both widths.
module tb_hist_cdf_accum;
  localparam int N = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       valid = 1'b0;
  logic       fend  = 1'b0;
  logic [9:0] inten = '0;

  logic        a_busy, a_vld, a_done, a_ovr;
  logic [7:0]  a_addr;
  logic [18:0] a_data;
  logic        b_busy, b_vld, b_done, b_ovr;
  logic [7:0]  b_addr;
  logic [3:0]  b_data;

  hist_cdf_accum #(.BIN_BITS(8), .CNT_W(19)) u_dut_a (
    .iCLK(clk), .iRST(rst), .iIntensity(inten), .iValid(valid), .iFrameEnd(fend),
    .oBusy(a_busy), .oCdfValid(a_vld), .oCdfAddr(a_addr), .oCdfData(a_data),
    .oFrameDone(a_done), .oOverrun(a_ovr)
  );

  hist_cdf_accum #(.BIN_BITS(8), .CNT_W(4)) u_dut_b (
    .iCLK(clk), .iRST(rst), .iIntensity(inten), .iValid(valid), .iFrameEnd(fend),
    .oBusy(b_busy), .oCdfValid(b_vld), .oCdfAddr(b_addr), .oCdfData(b_data),
    .oFrameDone(b_done), .oOverrun(b_ovr)
  );

  int total = 0;
  int bad   = 0;
  int hist [N];
  bit exp_ovr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_add(input int run, input int cnt, input int maxv);
    int c;
    c = (cnt > maxv) ? maxv : cnt;
    return (run + c > maxv) ? maxv : run + c;
  endfunction

  task automatic clear_model();
    foreach (hist[i]) hist[i] = 0;
  endtask

  // Reset for one edge, check reset values, then time the clear phase.
  task automatic do_reset();
    int n;
    bit noisy;
    rst = 1'b1; valid = 1'b0; fend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", a_busy, 1);
    check_eq("rst_cdf_valid", a_vld, 0);
    check_eq("rst_addr", a_addr, 0);
    check_eq("rst_data", a_data, 0);
    check_eq("rst_frame_done", a_done, 0);
    check_eq("rst_overrun_a", a_ovr, 0);
    check_eq("rst_overrun_b", b_ovr, 0);
    exp_ovr = 1'b0;
    clear_model();
    n = 0;
    noisy = 1'b0;
    while (a_busy && n < 1000) begin
      if (a_vld || a_done || b_vld || b_done) noisy = 1'b1;
      n++;
      @(negedge clk);
    end
    check_eq("clear_len", n, N);
    check_eq("clear_quiet", noisy, 0);
    check_eq("clear_busy_b", b_busy, 0);
  endtask

  task automatic pix(input int v);
    valid = 1'b1;
    inten = 10'(v);
    hist[v >> 2]++;
    @(negedge clk);
  endtask

  task automatic idle();
    valid = 1'b0;
    @(negedge clk);
  endtask

  // Pulse iFrameEnd (optionally with a coincident pixel) and check the CDF sweep.
  // drop_at: inject an ignored pixel after that many entries; abort_at: reset there.
  task automatic end_frame(input int coin, input int drop_at, input int abort_at);
    int c19 [N];
    int c4 [N];
    int run19, run4, a;
    bit done, dropped;
    if (coin >= 0) begin
      valid = 1'b1;
      inten = 10'(coin);
      hist[coin >> 2]++;
    end else begin
      valid = 1'b0;
    end
    fend = 1'b1;
    run19 = 0;
    run4  = 0;
    for (int b = 0; b < N; b++) begin
      run19  = sat_add(run19, hist[b], (1 << 19) - 1);
      run4   = sat_add(run4, hist[b], 15);
      c19[b] = run19;
      c4[b]  = run4;
    end
    @(negedge clk);
    valid = 1'b0;
    fend  = 1'b0;
    a = 0;
    done = 1'b0;
    dropped = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      valid = 1'b0;
      if (a_vld) begin
        if (a < N) begin
          check_eq("cdf_addr", a_addr, a);
          check_eq("cdf_data_w19", a_data, c19[a]);
          check_eq("cdf_data_w4", b_data, c4[a]);
          check_eq("cdf_valid_b", b_vld, 1);
        end else begin
          check_eq("cdf_extra_entry", a, N - 1);
        end
        a++;
      end
      if (a_done) begin
        done = 1'b1;
        check_eq("cdf_count", a, N);
        check_eq("done_valid_low", a_vld, 0);
        check_eq("done_busy_low", a_busy, 0);
        check_eq("hold_addr", a_addr, N - 1);
        check_eq("hold_data", a_data, c19[N-1]);
        check_eq("done_b", b_done, 1);
        check_eq("overrun_a", a_ovr, exp_ovr);
        check_eq("overrun_b", b_ovr, exp_ovr);
      end else if (a == abort_at) begin
        do_reset();
        return;
      end else if (a == drop_at && !dropped) begin
        valid   = 1'b1;
        inten   = '0;
        exp_ovr = 1'b1;
        dropped = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    check_eq("frame_done_seen", done, 1);
    @(negedge clk);
    check_eq("done_pulse_len", a_done, 0);
    clear_model();
  endtask

  initial begin
    int sparse [4];
    sparse = '{0, 4, 512, 1023};
    clear_model();
    repeat (3) @(negedge clk);

    do_reset();
    end_frame(-1, -1, -1);                       // empty frame -> all zeros

    foreach (sparse[i]) pix(sparse[i]);          // sparse bins 0,1,128,255
    end_frame(-1, -1, -1);

    repeat (100) pix(40);                        // same-bin bursts
    for (int i = 0; i < 50; i++) pix((i % 2 == 0) ? 40 : 44);
    end_frame(-1, -1, -1);

    for (int i = 0; i < 300; i++) begin          // random with gaps and hot bins
      if ($urandom_range(3) == 0) idle();
      else if ($urandom_range(1) == 0) pix(int'($urandom_range(1023)));
      else pix(16 + int'($urandom_range(7)));
    end
    end_frame(-1, -1, -1);

    end_frame(8, 100, -1);                       // coincident pixel; drop during sweep
    pix(20);                                     // bins cleared; overrun stays set
    end_frame(-1, -1, -1);

    repeat (20) pix(int'($urandom_range(3)));    // saturates the 4-bit instance
    end_frame(-1, -1, -1);

    for (int i = 0; i < 100; i++) pix(int'($urandom_range(1023)));
    end_frame(-1, -1, 50);                       // reset mid-sweep
    end_frame(-1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hist_cdf_accum.md
Name: hist_cdf_accum

Overview:
- Stage directly downstream of the per-pixel intensity calculator in the SRAM histogram-equalization path.
- Consumes one 10-bit intensity per valid cycle and bins it into a 2^BIN_BITS-entry histogram held in internal RAM.
- At end of frame, sweeps the bins in ascending order and streams the cumulative distribution (CDF), one bin per cycle, to the equalization LUT writer.
- Clears each bin during the sweep so the next frame starts from zero.

Parameters:
BIN_BITS, 8, log2 of bin count; bin index = iIntensity[9:10-BIN_BITS]
CNT_W, 19, width of bin counts and CDF values (640x480 = 307200 < 2^19)

Ports:
iCLK  input  1  pixel clock; all logic on rising edge
iRST  input  1  synchronous, active-high reset
iIntensity  input  10  pixel intensity
iValid  input  1  iIntensity valid this cycle
iFrameEnd  input  1  one-cycle pulse marking the last pixel cycle of a frame
oBusy  output  1  high while clearing, draining or sweeping; pixels are not accepted
oCdfValid  output  1  oCdfAddr/oCdfData valid this cycle
oCdfAddr  output  BIN_BITS  bin index of the current CDF entry
oCdfData  output  CNT_W  sum of bins 0..oCdfAddr, saturating
oFrameDone  output  1  one-cycle pulse after the last CDF entry
oOverrun  output  1  sticky flag: iValid or iFrameEnd arrived while oBusy

Behaviour:
- Reset (iRST high at a clock edge):
  - State becomes CLEAR and the bin address becomes 0.
  - oBusy=1. oCdfValid=0, oCdfAddr=0, oCdfData=0, oFrameDone=0, oOverrun=0.
  - Any in-flight pipeline write is discarded. Reset mid-sweep aborts the sweep with no further oCdfValid.
- CLEAR:
  - Writes 0 to bins 0..N-1 (N = 2^BIN_BITS), one per cycle: N cycles.
  - Then goes to ACCUM with oBusy=0.
- ACCUM (oBusy=0), iValid=1: bin b is updated through a 2-stage read-modify-write.
  - Stage 1: read bin b.
  - Stage 2: write count+1, saturating at 2^CNT_W-1.
  - Back-to-back or one-apart hits on the same bin forward the pending value, so every accepted pixel counts exactly once and throughput is 1 pixel/cycle.
- iFrameEnd in ACCUM:
  - A pixel with iValid in the same cycle is counted in the ending frame.
  - oBusy rises on the next cycle.
  - DRAIN: 2 cycles to retire the pipeline, then SCAN.
- SCAN: N consecutive cycles with oCdfValid=1.
  - oCdfAddr runs 0..N-1 ascending.
  - oCdfData = running sum including the current bin, saturating at 2^CNT_W-1.
  - Each bin is written to 0 in the cycle it is read.
- Cycle after the last SCAN entry:
  - oCdfValid=0 and oFrameDone=1 for exactly one cycle.
  - State returns to ACCUM, oBusy=0, and the running sum resets to 0.
- While oBusy=1:
  - iValid is ignored (the pixel is dropped) and iFrameEnd is ignored.
  - Either sets oOverrun, which stays set until iRST.
- Frame with no pixels: iFrameEnd still produces a full sweep of N zeros plus oFrameDone.
- Output updates: all outputs are registered. oCdfAddr and oCdfData hold their last values when oCdfValid=0.

Test Plan:
1. Reset:
   - Assert iRST 1 cycle -> oBusy=1 for exactly 256 cycles, then 0.
   - iFrameEnd with no pixels -> 256 oCdfValid cycles, all oCdfData=0, addrs 0..255; oFrameDone pulse the next cycle.
2. Sparse pixels: intensities 0, 4, 512, 1023 on consecutive cycles, then iFrameEnd -> CDF = 1 at addr 0, 2 at addrs 1..127, 3 at addrs 128..254, 4 at addr 255.
3. Forwarding:
   - 100 back-to-back pixels of intensity 40 (bin 10), plus alternating 40/44 x50 -> cdf[9]=0, cdf[10]=125, cdf[11]=150.
   - Confirms no lost increments.
4. Boundaries:
   - iValid coincident with iFrameEnd (intensity 8) -> counted: cdf[2]=1.
   - iValid during SCAN -> dropped, oOverrun=1.
   - Next frame of one pixel at bin 5 -> cdf[4]=0, cdf[255]=1 (bins were cleared).
5. Saturation: CNT_W=4, 20 pixels in bin 0 -> cdf[0]=15 and all later entries 15.
6. Reset mid-SCAN at addr 50:
   - oCdfValid drops the cycle after reset and no oFrameDone occurs.
   - After the 256-cycle CLEAR, an empty frame yields all-zero CDF.
